// File: rtl/rect_draw_ctrl_if.sv
// Request and pixel-stream bundle for the rectangle draw controller.
//   start/clear_req   : job requests (sampled by the controller in IDLE only)
//   x0/y0/w/h         : rectangle geometry
//   colour_in         : fill colour
//   x/y/colour/plot   : framebuffer pixel write port
//   busy/done         : job status
// master = requester/framebuffer side, slave = controller.
interface rect_draw_ctrl_if;
  logic       start;
  logic       clear_req;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, clear_req, x0, y0, w, h, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, clear_req, x0, y0, w, h, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rect_draw_ctrl.sv
// Rectangle fill controller: accepts a draw or clear-screen job, clips it to
// the screen and streams one pixel per cycle in row-major order.
//   clk    : rising-edge clock
//   resetb : synchronous active-low reset
//   bus    : request inputs and registered pixel/status outputs (slave side)
module rect_draw_ctrl #(
  parameter int unsigned SCR_W = 160,
  parameter int unsigned SCR_H = 120
) (
  input logic            clk,
  input logic            resetb,
  rect_draw_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] x0_q, x0_d;
  logic [6:0] y0_q, y0_d;
  logic [8:0] w_q, w_d;
  logic [8:0] h_q, h_d;
  logic [2:0] col_q, col_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Clipping in 9 bits so x0+w and the remaining span cannot wrap.
  logic [8:0] rem_w, rem_h, w_clip, h_clip;
  logic       empty;
  logic [7:0] x_last;
  logic [6:0] y_last;

  always_comb begin
    rem_w  = 9'(SCR_W) - 9'(x0_q);
    rem_h  = 9'(SCR_H) - 9'(y0_q);
    w_clip = (w_q < rem_w) ? w_q : rem_w;
    h_clip = (h_q < rem_h) ? h_q : rem_h;
    empty  = (9'(x0_q) >= 9'(SCR_W)) || (9'(y0_q) >= 9'(SCR_H)) ||
             (w_clip == 9'd0) || (h_clip == 9'd0);
    // Only meaningful in DRAW, where w_q/h_q already hold the clipped size.
    x_last = 8'(9'(x0_q) + w_q - 9'd1);
    y_last = 7'(9'(y0_q) + h_q - 9'd1);
  end

  // Next-state and datapath; status flops are aligned with the next state.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          x0_d    = 8'd0;
          y0_d    = 7'd0;
          w_d     = 9'(SCR_W);
          h_d     = 9'(SCR_H);
          col_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end else if (bus.start) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          w_d     = 9'(bus.w);
          h_d     = 9'(bus.h);
          col_d   = bus.colour_in;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        w_d = w_clip;
        h_d = h_clip;
        if (empty) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          x_d      = x0_q;
          y_d      = y0_q;
          colour_d = col_q;
          plot_d   = 1'b1;
          busy_d   = 1'b1;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if ((x_q == x_last) && (y_q == y_last)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          plot_d = 1'b1;
          busy_d = 1'b1;
          if (x_q == x_last) begin
            x_d = x0_q;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: doc/rect_draw_ctrl.md
RECT_DRAW_CTRL -- requirements
Module: rect_draw_ctrl

Interface
REQ-001 SHALL have parameter SCR_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCR_H, default 120, screen height in pixels.
REQ-003 clk  input  1  rising-edge clock; the block uses only this clock.
REQ-004 resetb  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  draw-rectangle request, sampled in IDLE only.
REQ-006 clear_req  input  1  clear-screen request, sampled in IDLE only.
REQ-007 x0  input  8  rectangle top-left x.
REQ-008 y0  input  7  rectangle top-left y.
REQ-009 w  input  8  rectangle width in pixels.
REQ-010 h  input  7  rectangle height in pixels.
REQ-011 colour_in  input  3  fill colour.
REQ-012 x  output  8  pixel x to framebuffer, registered.
REQ-013 y  output  7  pixel y to framebuffer, registered.
REQ-014 colour  output  3  pixel colour, registered.
REQ-015 plot  output  1  framebuffer write strobe, registered; one pixel per high cycle.
REQ-016 busy  output  1  high while a job is in LOAD or DRAW.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, LOAD, DRAW and DONE.
REQ-019 IDLE: if clear_req=1, capture x0'=0, y0'=0, w'=SCR_W, h'=SCR_H, colour=0, then go to LOAD.
REQ-020 IDLE: else if start=1, capture x0, y0, w, h and colour_in, then go to LOAD.
REQ-021 clear_req SHALL win over start when both are high in the same IDLE cycle; the start is dropped, not queued.
REQ-022 start and clear_req SHALL be ignored outside IDLE.
REQ-023 LOAD: clip the job to w' = min(w, SCR_W-x0) and h' = min(h, SCR_H-y0); compute in 9-bit arithmetic so x0+w cannot wrap.
REQ-024 LOAD: if x0>=SCR_W, y0>=SCR_H, w'=0 or h'=0, go to DONE with no pixel plotted; else initialise the counters to (x0,y0) and go to DRAW.
REQ-025 DRAW: each cycle, drive plot=1 with the current (x,y), and step x; when x reaches x0+w'-1, wrap x to x0 and increment y.
REQ-026 DRAW: after the pixel (x0+w'-1, y0+h'-1) is plotted, go to DONE.
REQ-027 Raster order SHALL be row-major (x inner); exactly w'*h' plot cycles per job, with no gaps and no repeated pixels.
REQ-028 DONE: done=1 and plot=0 for exactly one cycle, then unconditionally go to IDLE.
REQ-029 Latency: a request sampled at edge N SHALL give LOAD in cycle N+1 and the first plot in cycle N+2; done follows the last plot cycle immediately.
REQ-030 A new request SHALL be accepted no earlier than the IDLE cycle after DONE (minimum 3 cycles between jobs).
REQ-031 busy=1 in LOAD and DRAW only; busy=0 in IDLE and DONE.
REQ-032 x, y and colour SHALL hold their last values whenever plot=0.
REQ-033 Job inputs SHALL be sampled only at acceptance; input changes during a job have no effect.

Reset
REQ-034 When resetb=0 at a rising edge, the block SHALL enter IDLE and set plot=0, busy=0, done=0, x=0, y=0, colour=0 and all counters to 0.
REQ-035 Reset mid-job SHALL abort the job: no further plots and no done pulse; the job is not resumed after reset.
REQ-036 resetb SHALL take priority over all requests in the same cycle.

Verification
REQ-037 start, x0=10, y0=5, w=3, h=2, colour_in=5 -> 6 plot cycles at (10,5) (11,5) (12,5) (10,6) (11,6) (12,6), colour=5, first plot 2 cycles after start, then done=1 for one cycle.
REQ-038 clear_req and start high in the same IDLE cycle -> 19200 plots in raster order from (0,0) to (159,119) with colour=0, then one done pulse; the start is not executed.
REQ-039 start, x0=158, y0=118, w=10, h=10 -> 4 plots only, (158,118) (159,118) (158,119) (159,119), then done.
REQ-040 start with w=0, and separately with x0=200 -> zero plots, busy high for 1 cycle (LOAD), done pulse in the next cycle.
REQ-041 resetb=0 during the 4th pixel of a 5x5 job -> plot=0 from the next edge, no done pulse, idle with all outputs 0; a following start then runs to completion normally.
REQ-042 start pulsed repeatedly during DRAW -> no effect on the current job's pixels or pixel count, and no second job starts.
